// File: rtl/ndarray_slice_pkg.sv
// Shared types and helpers for the n-dimensional array slice pipeline:
// out-of-range policy enum, counter width and start-index normalisation.
package ndarray_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_CLAMP = 2'd0,
        SLICE_WRAP  = 2'd1,
        SLICE_ZERO  = 2'd2
    } slice_mode_e;

    localparam int OOB_CNT_W = 8;

    // Wide enough for any practical row count; callers keep the low IW bits.
    localparam int START_W = 16;

    typedef struct packed {
        logic [START_W-1:0] start;
        logic               oob;
    } norm_t;

    // Map a raw start index onto the row the window begins at, and report
    // whether the out-of-range policy had to step in.
    // CLAMP: pin to the last legal start. WRAP: reduce modulo rows, flag when
    // the index was reduced or the window runs past the last row. ZERO: keep
    // the index, flag when any window row falls beyond the array.
    function automatic norm_t normalise_index(input int unsigned xv,
                                              input int unsigned rows,
                                              input int unsigned win,
                                              input slice_mode_e   mode);
        norm_t       n;
        int unsigned lim;
        int unsigned xr;
        lim     = rows - win;
        xr      = xv % rows;
        n.start = START_W'(xv);
        n.oob   = 1'b0;
        case (mode)
            SLICE_CLAMP: begin
                if (xv > lim) begin
                    n.start = START_W'(lim);
                    n.oob   = 1'b1;
                end
            end
            SLICE_WRAP: begin
                n.start = START_W'(xr);
                n.oob   = (xv >= rows) || ((xr + win) > rows);
            end
            SLICE_ZERO: begin
                n.oob = ((xv + win) > rows);
            end
            default: begin
                n.oob = 1'b0;
            end
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ndarray_row_mux.sv
// Combinational window selector: picks WIN consecutive rows of the staged
// array starting at an already-normalised start row.
module ndarray_row_mux
    import ndarray_slice_pkg::*;
#(
    parameter int          ROWS = 6,
    parameter int          COLS = 3,
    parameter int          EW   = 2,
    parameter int          WIN  = 2,
    parameter int          IW   = $clog2(ROWS) + 1,
    parameter slice_mode_e MODE = SLICE_CLAMP
) (
    input  logic [ROWS*COLS*EW-1:0] arr,
    input  logic [IW-1:0]           start,
    output logic [WIN*COLS*EW-1:0]  win
);

    localparam int RW = COLS * EW;

    // Row k of the window is array row start+k, folded back to row 0 in WRAP
    // mode; rows past the end stay zero (only reachable in ZERO mode).
    always_comb begin
        int sel;
        win = '0;
        sel = 0;
        for (int k = 0; k < WIN; k++) begin
            sel = int'(start) + k;
            if (MODE == SLICE_WRAP && sel >= ROWS) begin
                sel = sel - ROWS;
            end
            for (int r = 0; r < ROWS; r++) begin
                if (sel == r) begin
                    win[k*RW +: RW] = arr[r*RW +: RW];
                end
            end
        end
    end

endmodule

// File: rtl/ndarray_slice_pipe.sv
// Two-stage valid/ready pipeline selecting a dynamically positioned window
// of rows from a packed ROWS x COLS x EW array, with out-of-range handling
// and a saturating count of out-of-range transfers.
module ndarray_slice_pipe
    import ndarray_slice_pkg::*;
#(
    parameter int ROWS = 6,
    parameter int COLS = 3,
    parameter int EW   = 2,
    parameter int WIN  = 2,
    parameter int MODE = 0,
    parameter int IW   = $clog2(ROWS) + 1
) (
    input  logic                    CLK,
    input  logic                    ASYNCRESETN,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*COLS*EW-1:0] I,
    input  logic [IW-1:0]           x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIN*COLS*EW-1:0]  O,
    output logic                    oob,
    output logic [OOB_CNT_W-1:0]    oob_count
);

    localparam slice_mode_e MODE_E = slice_mode_e'(MODE[1:0]);

    function automatic logic [OOB_CNT_W-1:0] sat_inc(input logic [OOB_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic                    s1_adv;
    logic                    s2_adv;
    logic                    in_fire;
    norm_t                   norm_in;
    logic                    unused_start_hi;

    logic                    vld_p1;
    logic [ROWS*COLS*EW-1:0] arr_p1;
    logic [IW-1:0]           start_p1;
    logic                    oob_p1;
    logic [WIN*COLS*EW-1:0]  win_p1;

    logic                    vld_p2;
    logic [WIN*COLS*EW-1:0]  o_p2;
    logic                    oob_p2;
    logic [OOB_CNT_W-1:0]    cnt;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_adv   = !vld_p2 || out_ready;
    assign s1_adv   = !vld_p1 || s2_adv;
    assign in_ready = s1_adv;
    assign in_fire  = in_valid && s1_adv;

    assign norm_in         = normalise_index(32'(x), ROWS, WIN, MODE_E);
    assign unused_start_hi = ^norm_in.start[START_W-1:IW];

    // ---- stage S1: raw array, normalised start, oob flag ----

    // S1 occupancy; cleared by reset so in-flight data is dropped.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            vld_p1 <= 1'b0;
        end else if (s1_adv) begin
            vld_p1 <= in_valid;
        end
    end

    // S1 payload; qualified by vld_p1 so it needs no reset.
    always_ff @(posedge CLK) begin
        if (in_fire) begin
            arr_p1   <= I;
            start_p1 <= norm_in.start[IW-1:0];
            oob_p1   <= norm_in.oob;
        end
    end

    // Count every accepted transfer that needed the out-of-range policy.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            cnt <= '0;
        end else if (in_fire && norm_in.oob) begin
            cnt <= sat_inc(cnt);
        end
    end

    ndarray_row_mux #(
        .ROWS (ROWS),
        .COLS (COLS),
        .EW   (EW),
        .WIN  (WIN),
        .IW   (IW),
        .MODE (MODE_E)
    ) u_row_mux (
        .arr   (arr_p1),
        .start (start_p1),
        .win   (win_p1)
    );

    // ---- stage S2: selected window and its oob flag ----

    // S2 register; holds while the consumer stalls, zeroed on reset.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            vld_p2 <= 1'b0;
            o_p2   <= '0;
            oob_p2 <= 1'b0;
        end else if (s2_adv) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                o_p2   <= win_p1;
                oob_p2 <= oob_p1;
            end
        end
    end

    assign out_valid = vld_p2;
    assign O         = o_p2;
    assign oob       = oob_p2;
    assign oob_count = cnt;

endmodule

// File: doc/ndarray_slice_pipe.md
# ndarray_slice_pipe

- Parametrised, pipelined dynamic-slice selector for packed n-dimensional arrays.
- Selects a window of `WIN` consecutive rows, starting at a runtime index `x`, from a `ROWS × COLS × EW` input array.
- Out-of-range indices are handled by a configurable policy (clamp, wrap or zero-fill), and each such event is flagged and counted.
- Sits between array-producing datapath stages and consumers that need a dynamically positioned window, with valid/ready flow control on both sides.

## Interface

Parameters:
- `ROWS`, 6: rows in the input array; must be ≥ 2.
- `COLS`, 3: columns per row.
- `EW`, 2: element width in bits.
- `WIN`, 2: rows in the output window; must satisfy 1 ≤ `WIN` ≤ `ROWS`.
- `MODE`, 0: out-of-range policy; 0 = CLAMP, 1 = WRAP, 2 = ZERO.
- `IW`, $clog2(`ROWS`)+1: index width; derived, not overridden.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `ASYNCRESETN`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input transfer request.
- `in_ready`  out  1  block can accept an input this cycle.
- `I`  in  `ROWS*COLS*EW`  input array; element (r,c) is at bits [(r*COLS+c)*EW +: EW].
- `x`  in  `IW`  window start row, unsigned.
- `out_valid`  out  1  output window valid.
- `out_ready`  in  1  consumer accepts the output this cycle.
- `O`  out  `WIN*COLS*EW`  output window; element (k,c) is at bits [(k*COLS+c)*EW +: EW].
- `oob`  out  1  the current output was produced under the out-of-range policy.
- `oob_count`  out  8  saturating count of accepted out-of-range transfers.

## Operation

- Input transfer occurs when `in_valid && in_ready`. Output transfer occurs when `out_valid && out_ready`.
- Two-stage pipeline:
  - **S1** registers `I` and the normalised start index, plus an oob bit.
  - **S2** registers `O` and `oob`.
- Legal start indices are 0 .. `ROWS-WIN`. An index above `ROWS-WIN` is out of range.
- MODE CLAMP: an out-of-range start is replaced by `ROWS-WIN`; `oob`=1.
- MODE WRAP: window row k = (x+k) mod `ROWS`; x is first reduced mod `ROWS`. `oob`=1 only when the window wraps or x ≥ `ROWS`.
- MODE ZERO: window row k = I row (x+k) if x+k < `ROWS`, otherwise all zeros; `oob`=1 when any row is zero-filled.
- `oob_count` increments by 1 on each S1 capture with oob=1 and saturates at 255.
- Reset state:
  - both stages empty; `out_valid`=0, `O`=0, `oob`=0, `oob_count`=0;
  - `in_ready`=1 once reset is released.
- Reset asserted mid-operation: in-flight data is discarded. There is no partial output.

## Timing

- Latency is 2 cycles from input transfer to `out_valid`, with no stalls.
- Throughput is one transfer per cycle while `out_ready` is held at 1.
- Stage advance rules:
  - s2_adv = !s2_valid || `out_ready`
  - s1_adv = !s1_valid || s2_adv
  - `in_ready` = s1_adv, combinational. There is no combinational path from `in_valid` to `out_valid`.
- While `out_valid`=1 and `out_ready`=0, `O` and `oob` hold stable. The pipeline holds at most 2 entries; a third input is refused (`in_ready`=0).
- When an output transfer and an input transfer happen in the same cycle on a full pipeline, both complete. No bubble is inserted.
- `oob_count` updates in the cycle after the S1 capture edge.

## Structure

- Package `ndarray_slice_pkg` holds:
  - the mode enum (`SLICE_CLAMP`, `SLICE_WRAP`, `SLICE_ZERO`);
  - the counter width constant (8);
  - the index-normalisation function (x, `ROWS`, `WIN`, mode → start row, oob).
- Sub-module `ndarray_row_mux` is a purely combinational selector: it takes the S1 array, start index and mode, and produces the `WIN`-row window. It is instantiated once, between S1 and S2.

## Test plan

Defaults `ROWS`=6, `COLS`=3, `EW`=2, `WIN`=2 unless stated; row r elements = r mod 4.

1. CLAMP, x=0,1,2,3,4 with `out_ready`=1 → after 2 cycles each, O rows = (x, x+1) mod 4; `oob`=0; back-to-back outputs with no gaps.
2. CLAMP, x=5 → O rows = I rows 4,5 (values 0,1); `oob`=1; `oob_count`=1.
3. WRAP, x=5 → O rows = I rows 5,0 (values 1,0); `oob`=1. Then x=7 → O rows = I rows 1,2; `oob`=1; `oob_count`=2.
4. ZERO, x=5 → O row 0 = I row 5, O row 1 = all zeros; `oob`=1.
5. Backpressure: hold `out_ready`=0 for 5 cycles while driving 3 inputs →
   - `in_ready` drops after 2 accepts;
   - `O` stays stable;
   - releasing `out_ready` drains in order with no loss or duplication.
6. Reset: assert `ASYNCRESETN`=0 mid-stream → `out_valid`, `O`, `oob` and `oob_count` go to 0 immediately. Also drive 300 out-of-range inputs → `oob_count` saturates at 255.
